// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release strobes
// and auto-repeat while the button is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_RATE     = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_e;

    localparam logic [CNT_W-1:0] DB_C    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = '0;
    localparam bit               DB_ONE  = (DEBOUNCE_CYCLES <= 1);
    localparam bit               RATE_OFF = (REPEAT_RATE == 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE_C;
    endfunction

    logic             sync1_q;
    logic             sync2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic [CNT_W-1:0] db_inc;
    logic [CNT_W-1:0] rep_inc;
    logic [CNT_W-1:0] rep_tgt;

    // The synchronizer keeps sampling even while the rest is frozen by ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;
        db_inc      = sat_inc(db_cnt_q);
        rep_inc     = sat_inc(rep_cnt_q);
        rep_tgt     = rep_first_q ? RATE_C : DELAY_C;

        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        if (DB_ONE) begin
                            state_d     = HELD;
                            db_cnt_d    = ZERO_C;
                            level_d     = 1'b1;
                            press_d     = 1'b1;
                            rep_cnt_d   = ZERO_C;
                            rep_first_d = 1'b0;
                        end else begin
                            state_d  = PRESS_DB;
                            db_cnt_d = ONE_C;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!sync2_q) begin
                        state_d  = IDLE;
                        db_cnt_d = ZERO_C;
                    end else if (db_inc >= DB_C) begin
                        state_d     = HELD;
                        db_cnt_d    = ZERO_C;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                        rep_cnt_d   = ZERO_C;
                        rep_first_d = 1'b0;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        if (DB_ONE) begin
                            state_d   = IDLE;
                            db_cnt_d  = ZERO_C;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d  = RELEASE_DB;
                            db_cnt_d = ONE_C;
                        end
                    end else if (!(rep_first_q && RATE_OFF)) begin
                        // Timer only advances on cycles that stay in HELD.
                        if (rep_inc >= rep_tgt) begin
                            repeat_d    = 1'b1;
                            rep_cnt_d   = ZERO_C;
                            rep_first_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (sync2_q) begin
                        state_d  = HELD;
                        db_cnt_d = ZERO_C;
                    end else if (db_inc >= DB_C) begin
                        state_d   = IDLE;
                        db_cnt_d  = ZERO_C;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    db_cnt_d = ZERO_C;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized + directed bench for button_conditioner with a scoreboard fed
// by a level/run-length reference model.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int DL = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(DL),
        .REPEAT_RATE(RR),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse)
    );

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;
    logic sy = 1'b0;
    logic lvl_m = 1'b0;
    int   run = 0;
    int   held_t = 0;
    int   last_press = -1;
    int   rep_seen[$];

    function automatic bit is_rep(input int t);
        return (t == DL) || (RR != 0 && t > DL && ((t - DL) % RR) == 0);
    endfunction

    // Reference: a level change is accepted after D consecutive enabled
    // samples disagreeing with the accepted level; hold time advances only
    // on enabled samples that agree with a held level and no release pending.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 = 1'b0;
            s2 = 1'b0;
            lvl_m = 1'b0;
            run = 0;
            held_t = 0;
            exp_q.delete();
        end else begin
            edge_cnt++;
            sy = s2;
            s2 = s1;
            s1 = btn_raw;
            if (ena) begin
                if (sy != lvl_m) begin
                    run++;
                    if (run == D) begin
                        lvl_m = sy;
                        run = 0;
                        if (lvl_m) begin
                            held_t = 0;
                            exp_q.push_back('{0, edge_cnt});
                        end else begin
                            exp_q.push_back('{1, edge_cnt});
                        end
                    end
                end else begin
                    if (lvl_m && run == 0) begin
                        held_t++;
                        if (is_rep(held_t)) exp_q.push_back('{2, edge_cnt});
                    end
                    run = 0;
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT shows a strobe.
    always begin
        int  n;
        int  k;
        ev_t e;
        @(posedge clk);
        #1;
        if (rst_n) begin
            total++;
            if (btn_level !== lvl_m) begin
                bad++;
                $display("FAIL level edge=%0d got=%b want=%b",
                         edge_cnt, btn_level, lvl_m);
            end
            n = int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse);
            if (n > 1) begin
                total++;
                bad++;
                $display("FAIL exclusive edge=%0d got=%0d strobes want<=1",
                         edge_cnt, n);
            end else if (n == 1) begin
                k = press_pulse ? 0 : (release_pulse ? 1 : 2);
                if (k == 0) last_press = edge_cnt;
                if (k == 2) rep_seen.push_back(edge_cnt);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected edge=%0d got kind=%0d want none",
                             edge_cnt, k);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.cyc != edge_cnt) begin
                        bad++;
                        $display("FAIL event got kind=%0d@%0d want kind=%0d@%0d",
                                 k, edge_cnt, e.kind, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing edge=%0d got none want kind=%0d@%0d",
                         edge_cnt, e.kind, e.cyc);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drive(input logic b, input logic e, input int n);
        @(negedge clk);
        btn_raw = b;
        ena = e;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_lvl"}, int'(btn_level), 0);
        check({tag, "_prs"}, int'(press_pulse), 0);
        check({tag, "_rel"}, int'(release_pulse), 0);
        check({tag, "_rep"}, int'(repeat_pulse), 0);
    endtask

    initial begin
        int k;
        int p;
        repeat (3) @(negedge clk);
        #1;
        outs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 5);

        // clean press, latency and repeat cadence
        rep_seen.delete();
        @(negedge clk);
        btn_raw = 1'b1;
        @(posedge clk);
        #1;
        k = edge_cnt;
        drive(1, 1, 30);
        check("press_lat", last_press, k + 5);
        p = last_press;
        check("rep_count", (rep_seen.size() >= 3) ? 1 : 0, 1);
        if (rep_seen.size() >= 3) begin
            check("rep0", rep_seen[0], p + 10);
            check("rep1", rep_seen[1], p + 13);
            check("rep2", rep_seen[2], p + 16);
        end
        drive(0, 1, 12);
        check("released", int'(btn_level), 0);

        // bounce on press
        drive(1, 1, 3);
        drive(0, 1, 1);
        drive(1, 1, 20);
        drive(0, 1, 12);

        // release glitch while held
        drive(1, 1, 10);
        drive(0, 1, 2);
        drive(1, 1, 20);
        check("glitch_lvl", int'(btn_level), 1);
        drive(0, 1, 12);

        // ena freeze during hold
        drive(1, 1, 12);
        drive(1, 0, 20);
        check("frz_lvl", int'(btn_level), 1);
        drive(1, 1, 15);
        drive(0, 1, 12);

        // reset mid-hold, then release with no strobe
        @(negedge clk);
        btn_raw = 1'b1;
        @(posedge clk);
        #1;
        k = edge_cnt;
        repeat (10) @(negedge clk);
        check("pre_rst_lvl", int'(btn_level), 1);
        rst_n = 1'b0;
        #1;
        outs_zero("midrst");
        btn_raw = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 15);
        outs_zero("postrst");

        // reset released with the button already down
        @(negedge clk);
        rst_n = 1'b0;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        k = edge_cnt;
        drive(1, 1, 12);
        check("rst_press", last_press, k + 5);
        drive(0, 1, 12);

        // random stimulus
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) != 0),
                  $urandom_range(1, 25));
        end
        drive(0, 1, 20);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
